// File: rtl/bsg_mem_1rw_arb_init.sv
// Front-end controller for a single-port byte-masked memory wrapper.
// After reset (or a clear_i pulse) it writes init_val_p into every entry.
// It then shares the one port between two requesters using round-robin
// arbitration. Read data comes back one cycle after the read transfers.
module bsg_mem_1rw_arb_init #(
  parameter int                 width_p    = 64,
  parameter int                 els_p      = 512,
  parameter logic [width_p-1:0] init_val_p = '0,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p >> 3
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  output logic                       init_done_o,
  input  logic [1:0]                 v_i,
  input  logic [1:0]                 w_i,
  input  logic [2*addr_width_lp-1:0] addr_i,
  input  logic [2*width_p-1:0]       data_i,
  input  logic [2*mask_width_lp-1:0] mask_i,
  output logic [1:0]                 ready_o,
  output logic [1:0]                 data_v_o,
  output logic [width_p-1:0]         data_o,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  output logic [mask_width_lp-1:0]   mem_w_mask_o,
  input  logic [width_p-1:0]         mem_data_i
);

  typedef enum logic {eClear, eRun} state_e;

  // The terminal count is compared exactly, so non-power-of-2 depths never
  // wrap the counter or touch addresses beyond the array.
  localparam logic [addr_width_lp-1:0] lastAddrLp = addr_width_lp'(els_p - 1);

  state_e                   state_q;
  logic [addr_width_lp-1:0] cnt_q;
  logic                     last_q;
  logic [1:0]               data_v_q;

  logic       grant;
  logic       xfer;
  logic       rdXfer;
  logic [1:0] grantOneHot;

  // Round-robin pick: a lone requester wins; on contention the requester
  // that did not win last time gets the port.
  always_comb begin
    grant = 1'b0;
    unique case (v_i)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  assign grantOneHot = grant ? 2'b10 : 2'b01;
  assign ready_o     = ((state_q == eRun) && (|v_i)) ? grantOneHot : 2'b00;
  assign xfer        = |(v_i & ready_o);
  assign rdXfer      = xfer & ~(grant ? w_i[1] : w_i[0]);

  // Drive the memory port from the clear sequencer or from the granted requester.
  always_comb begin
    mem_v_o      = 1'b1;
    mem_w_o      = 1'b1;
    mem_addr_o   = cnt_q;
    mem_data_o   = init_val_p;
    mem_w_mask_o = '1;
    if (state_q == eRun) begin
      mem_v_o      = |v_i;
      mem_w_o      = grant ? w_i[1] : w_i[0];
      mem_addr_o   = grant ? addr_i[2*addr_width_lp-1:addr_width_lp]
                           : addr_i[addr_width_lp-1:0];
      mem_data_o   = grant ? data_i[2*width_p-1:width_p]
                           : data_i[width_p-1:0];
      mem_w_mask_o = grant ? mask_i[2*mask_width_lp-1:mask_width_lp]
                           : mask_i[mask_width_lp-1:0];
    end
  end

  // Control FSM. It sequences the clear, records the last grant, and tags
  // the read response that returns next cycle. A read accepted in the same
  // cycle as clear_i still gets its response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eClear;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      data_v_q <= 2'b00;
    end else begin
      unique case (state_q)
        eClear: begin
          data_v_q <= 2'b00;
          if (cnt_q == lastAddrLp) begin
            cnt_q   <= '0;
            state_q <= eRun;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        eRun: begin
          data_v_q <= rdXfer ? grantOneHot : 2'b00;
          if (xfer) begin
            last_q <= grant;
          end
          if (clear_i) begin
            state_q <= eClear;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= eClear;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign init_done_o = (state_q == eRun);
  assign data_v_o    = data_v_q;
  assign data_o      = mem_data_i;

endmodule

// File: tb/tb_bsg_mem_1rw_arb_init.sv
// Testbench for bsg_mem_1rw_arb_init.
// It drives directed scenarios and random traffic. A behavioural model
// predicts grants, memory-port contents, clear progress and read data.
// A simple 1-cycle-latency memory stands in for the hard macro.
module tb_bsg_mem_1rw_arb_init;

  localparam int W    = 64;
  localparam int ELS  = 512;
  localparam int AW   = 9;
  localparam int MW   = 8;
  localparam logic [W-1:0] INIT = '0;

  logic            clk;
  logic            resetN;
  logic            clearI;
  logic            initDone;
  logic [1:0]      vI;
  logic [1:0]      wI;
  logic [2*AW-1:0] addrI;
  logic [2*W-1:0]  dataI;
  logic [2*MW-1:0] maskI;
  logic [1:0]      readyO;
  logic [1:0]      dataV;
  logic [W-1:0]    dataO;
  logic            memV;
  logic            memW;
  logic [AW-1:0]   memAddr;
  logic [W-1:0]    memData;
  logic [MW-1:0]   memMask;
  logic [W-1:0]    memRd;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model state.
  logic [W-1:0] refMem [ELS];
  bit           refRun;
  int           refCnt;
  int           lastPtr;
  logic [1:0]   expDv;
  logic [W-1:0] expData;

  // Stand-in for the macro.
  logic [W-1:0] physMem [ELS];

  bsg_mem_1rw_arb_init #(.width_p(W), .els_p(ELS), .init_val_p(INIT)) dut (
    .clk_i(clk), .reset_n_i(resetN), .clear_i(clearI), .init_done_o(initDone),
    .v_i(vI), .w_i(wI), .addr_i(addrI), .data_i(dataI), .mask_i(maskI),
    .ready_o(readyO), .data_v_o(dataV), .data_o(dataO),
    .mem_v_o(memV), .mem_w_o(memW), .mem_addr_o(memAddr), .mem_data_o(memData),
    .mem_w_mask_o(memMask), .mem_data_i(memRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-masked memory with registered read data.
  always @(posedge clk) begin
    if (memV) begin
      if (memW) begin
        for (int b = 0; b < MW; b++)
          if (memMask[b]) physMem[memAddr][b*8 +: 8] <= memData[b*8 +: 8];
      end else begin
        memRd <= physMem[memAddr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle. Entered and left at a negative edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                               input logic clr);
    int g;
    logic [1:0]    nextDv;
    logic [W-1:0]  nextData;
    logic [AW-1:0] ga;
    logic [W-1:0]  gd;
    logic [MW-1:0] gm;
    checkOutput("dataV", dataV, expDv);
    if (expDv != 2'b00) checkOutput("dataO", dataO, expData);
    vI = v; wI = w; addrI = {a1, a0}; dataI = {d1, d0}; maskI = {m1, m0}; clearI = clr;
    #1;
    nextDv = 2'b00;
    nextData = '0;
    if (!refRun) begin
      checkOutput("initDoneClr", initDone, 0);
      checkOutput("readyClr", readyO, 0);
      checkOutput("memVClr", memV, 1);
      checkOutput("memWClr", memW, 1);
      checkOutput("memAddrClr", memAddr, refCnt);
      checkOutput("memDataClr", memData, INIT);
      checkOutput("memMaskClr", memMask, {MW{1'b1}});
      @(posedge clk);
      refMem[refCnt] = INIT;
      refCnt++;
      if (refCnt == ELS) begin
        refRun = 1;
        refCnt = 0;
      end
    end else begin
      g = (v == 2'b11) ? (lastPtr == 0 ? 1 : 0) : (v == 2'b10 ? 1 : 0);
      ga = g ? a1 : a0;
      gd = g ? d1 : d0;
      gm = g ? m1 : m0;
      checkOutput("initDoneRun", initDone, 1);
      checkOutput("ready", readyO, (v == 2'b00) ? 2'b00 : (2'b01 << g));
      checkOutput("memV", memV, |v);
      if (v != 2'b00) begin
        checkOutput("memW", memW, w[g]);
        checkOutput("memAddr", memAddr, ga);
        if (w[g]) begin
          checkOutput("memData", memData, gd);
          checkOutput("memMask", memMask, gm);
        end
      end
      @(posedge clk);
      if (v != 2'b00) begin
        if (w[g]) begin
          for (int b = 0; b < MW; b++)
            if (gm[b]) refMem[ga][b*8 +: 8] = gd[b*8 +: 8];
        end else begin
          nextDv = 2'b01 << g;
          nextData = refMem[ga];
        end
        lastPtr = g;
      end
      if (clr) begin
        refRun = 0;
        refCnt = 0;
      end
    end
    expDv = nextDv;
    expData = nextData;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitRun();
    int budget = 0;
    while (!refRun && budget < ELS + 20) begin
      idle(1);
      budget++;
    end
    checkOutput("clearFinished", refRun, 1);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    #1;
    checkOutput("dvReset", dataV, 0);
    checkOutput("initDoneReset", initDone, 0);
    checkOutput("readyReset", readyO, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    refRun = 0; refCnt = 0; lastPtr = 1; expDv = 2'b00; expData = '0;
  endtask

  initial begin
    for (int i = 0; i < ELS; i++) physMem[i] = {$urandom, $urandom};
    for (int i = 0; i < ELS; i++) refMem[i] = 'x;
    memRd = '0;
    resetN = 1'b0; clearI = 0; vI = 0; wI = 0; addrI = 0; dataI = 0; maskI = 0;
    refRun = 0; refCnt = 0; lastPtr = 1; expDv = 2'b00; expData = '0;
    repeat (3) @(negedge clk);
    checkOutput("dvAtReset", dataV, 0);
    checkOutput("initDoneAtReset", initDone, 0);
    checkOutput("memVAtReset", memV, 1);
    resetN = 1'b1;

    // Initial clear, then read addr 37.
    waitRun();
    applyStimulus(2'b01, 2'b00, 37, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Masked write then read-back of addr 5.
    applyStimulus(2'b01, 2'b01, 5, 0, 64'h1122334455667788, 0, 8'h0F, 0, 0);
    applyStimulus(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Both requesters reading for 6 cycles.
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 2'b00, 5, 37, 0, 0, 0, 0, 0);
    idle(1);

    // Requester 1 alone three times, then contention.
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 2'b00, 0, 5, 0, 0, 0, 0, 0);
    applyStimulus(2'b11, 2'b00, 5, 5, 0, 0, 0, 0, 0);
    idle(1);

    // Write 9, then read 9 together with a clear pulse.
    applyStimulus(2'b01, 2'b01, 9, 0, 64'hDEADBEEFCAFEF00D, 0, 8'hFF, 0, 0);
    applyStimulus(2'b10, 2'b00, 0, 9, 0, 0, 0, 0, 1);
    applyStimulus(2'b11, 2'b11, 3, 4, 64'h1, 64'h2, 8'hFF, 8'hFF, 1);
    waitRun();
    applyStimulus(2'b01, 2'b00, 9, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset in the middle of a clear at counter 200.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    while (refCnt < 200) idle(1);
    doReset();
    waitRun();

    // Reset while a read response is pending.
    applyStimulus(2'b01, 2'b01, 7, 0, 64'h0123456789ABCDEF, 0, 8'hFF, 0, 0);
    applyStimulus(2'b01, 2'b00, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("dvBeforeReset", dataV, 2'b01);
    doReset();
    waitRun();

    // Random traffic over a small address window, with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(2'($urandom), 2'($urandom), AW'($urandom_range(0, 15)),
                    AW'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                    MW'($urandom), MW'($urandom), ($urandom_range(0, 499) == 0));
    end
    waitRun();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
